// File: rtl/fifo_seq_pkg.sv
// Shared types and constants for the FIFO sequence writer.
// FIFO_SEQ_WRITER_LFSR_EN selects the LFSR sequence in place of the incrementing one.
package fifo_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Galois feedback taps, maximal length for a 16-bit register; narrower or
  // wider builds use the low WIDTH bits.
  localparam logic [63:0] LFSR_TAP_MASK = 64'h0000_0000_0000_B400;

  localparam int GAP_W = 8;

endpackage

// File: rtl/fifo_seq_writer_if.sv
// FIFO write-side bus: write enable and data towards the FIFO, full flag back.
interface fifo_seq_writer_if #(
  parameter int WIDTH = 16
);

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             full;

  modport master (
    output wr_en,
    output wr_data,
    input  full
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output full
  );

endinterface

// File: rtl/fifo_seq_next.sv
// Combinational next-value generator for the write-data sequence.
// FIFO_SEQ_WRITER_LFSR_EN selects one Galois LFSR step; otherwise value + 1 mod 2^WIDTH.
module fifo_seq_next
  import fifo_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

`ifdef FIFO_SEQ_WRITER_LFSR_EN
  localparam logic [WIDTH-1:0] TAPS = LFSR_TAP_MASK[WIDTH-1:0];

  // NOTE: every output of a combinational block is assigned before any
  // conditional update, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    nxt = cur >> 1;
    if (cur[0]) begin
      nxt = nxt ^ TAPS;
    end
  end
`else
  always_comb begin
    nxt = cur + 1'b1;
  end
`endif

endmodule

// File: rtl/fifo_seq_writer.sv
// Burst writer: emits burst_len sequential words into a FIFO with optional gaps.
// FIFO_SEQ_WRITER_LFSR_EN switches the data sequence to an LFSR (seed 0 becomes 1).
module fifo_seq_writer
  import fifo_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CNT_W-1:0]        burst_len,
  input  logic [GAP_W-1:0]        gap_cycles,
  input  logic [WIDTH-1:0]        seed,
  fifo_seq_writer_if.master       fifo,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        wr_count
);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] len_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] pause_cnt;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_next;
  logic [WIDTH-1:0] seed_init;
  logic [CNT_W-1:0] count_inc;
  logic             accept;
  logic             launch;

`ifdef FIFO_SEQ_WRITER_LFSR_EN
  // An all-zero LFSR state never leaves zero.
  assign seed_init = (seed == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : seed;
`else
  assign seed_init = seed;
`endif

  fifo_seq_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .cur (data_q),
    .nxt (data_next)
  );

  assign count_inc = wr_count + 1'b1;
  assign launch    = (state == IDLE) && start;

  always_comb begin
    state_n = state;
    accept  = (state == WRITE) && !fifo.full;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = (burst_len == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        // A write landing on the abort cycle is still accepted and counted.
        if (abort) begin
          state_n = IDLE;
        end else if (accept) begin
          if (count_inc == len_q) begin
            state_n = DONE;
          end else if (gap_q != '0) begin
            state_n = PAUSE;
          end
        end
      end
      PAUSE: begin
        if (abort) begin
          state_n = IDLE;
        end else if (pause_cnt == GAP_W'(1)) begin
          state_n = WRITE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // NOTE: the captured burst parameters are reset too; they are cheap flops,
  // and a defined post-reset value keeps the datapath free of X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      gap_q     <= '0;
      pause_cnt <= '0;
      data_q    <= '0;
      wr_count  <= '0;
    end else begin
      if (launch) begin
        len_q    <= burst_len;
        gap_q    <= gap_cycles;
        wr_count <= '0;
        data_q   <= seed_init;
      end else if (accept) begin
        wr_count <= count_inc;
        data_q   <= data_next;
      end

      if ((state == WRITE) && (state_n == PAUSE)) begin
        pause_cnt <= gap_q;
      end else if (state == PAUSE) begin
        pause_cnt <= pause_cnt - 1'b1;
      end
    end
  end

  assign fifo.wr_en   = accept;
  assign fifo.wr_data = data_q;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_fifo_seq_writer.sv
// Directed bench for fifo_seq_writer: stimulus pushes expected words into a
// scoreboard queue, a monitor pops and compares on every observed write.
module tb_fifo_seq_writer;

  localparam int WIDTH = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] burst_len;
  logic [7:0]       gap_cycles;
  logic [WIDTH-1:0] seed;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] wr_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] exp_q[$];

  fifo_seq_writer_if #(.WIDTH(WIDTH)) fifo ();

  fifo_seq_writer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .burst_len  (burst_len),
    .gap_cycles (gap_cycles),
    .seed       (seed),
    .fifo       (fifo.master),
    .busy       (busy),
    .done       (done),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a start and return one cycle later, in the first post-start cycle.
  task automatic start_burst(input logic [WIDTH-1:0] s, input logic [CNT_W-1:0] len,
                             input logic [7:0] gap);
    seed       = s;
    burst_len  = len;
    gap_cycles = gap;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Monitor: every observed write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo.wr_en && fifo.full) begin
        n_tests++;
        n_fail++;
        $display("FAIL wr_en_while_full: wr_en=1 with full=1");
      end
      if (fifo.wr_en) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got 0x%0h with empty scoreboard", fifo.wr_data);
        end else begin
          check("sb_wr_data", 64'(fifo.wr_data), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    burst_len  = '0;
    gap_cycles = '0;
    seed       = '0;
    fifo.full  = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_wr_en",    64'(fifo.wr_en),   64'd0);
    check("rst_busy",     64'(busy),         64'd0);
    check("rst_done",     64'(done),         64'd0);
    check("rst_wr_count", 64'(wr_count),     64'd0);
    check("rst_wr_data",  64'(fifo.wr_data), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Basic burst; start held high and inputs changed while busy must be ignored
    exp_q.push_back(16'h0010);
    exp_q.push_back(16'h0011);
    exp_q.push_back(16'h0012);
    exp_q.push_back(16'h0013);
    start_burst(16'h0010, 16'd4, 8'd0);
    start     = 1'b1;
    burst_len = 16'd9;
    seed      = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("basic_wr_en", 64'(fifo.wr_en), 64'd1);
      check("basic_done_low", 64'(done), 64'd0);
      if (i == 1) start = 1'b0;
      tick();
    end
    @(negedge clk);
    check("basic_done",     64'(done),     64'd1);
    check("basic_wr_en_dn", 64'(fifo.wr_en), 64'd0);
    check("basic_count",    64'(wr_count), 64'd4);
    tick();
    @(negedge clk);
    check("basic_done_end", 64'(done), 64'd0);
    check("basic_idle",     64'(busy), 64'd0);
    check("basic_hold_cnt", 64'(wr_count), 64'd4);
    check("basic_hold_dat", 64'(fifo.wr_data), 64'h0014);
    check("basic_sb_empty", 64'(exp_q.size()), 64'd0);
    tick();

    // Backpressure: full for 5 cycles after the first write
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0101);
    exp_q.push_back(16'h0102);
    start_burst(16'h0100, 16'd3, 8'd0);
    @(negedge clk);
    check("bp_first_wr", 64'(fifo.wr_en), 64'd1);
    tick();
    fifo.full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_stall_wr_en", 64'(fifo.wr_en),   64'd0);
      check("bp_stall_count", 64'(wr_count),     64'd1);
      check("bp_stall_data",  64'(fifo.wr_data), 64'h0101);
      check("bp_stall_busy",  64'(busy),         64'd1);
      tick();
    end
    fifo.full = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_resume_wr", 64'(fifo.wr_en), 64'd1);
      tick();
    end
    @(negedge clk);
    check("bp_done",     64'(done),     64'd1);
    check("bp_count",    64'(wr_count), 64'd3);
    check("bp_sb_empty", 64'(exp_q.size()), 64'd0);
    tick();
    tick();

    // Gaps and wrap: 0xFFFF then 0x0000 with two idle cycles between
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    start_burst(16'hFFFF, 16'd2, 8'd2);
    @(negedge clk);
    check("gap_wr1", 64'(fifo.wr_en), 64'd1);
    tick();
    @(negedge clk);
    check("gap_idle1", 64'(fifo.wr_en), 64'd0);
    check("gap_busy1", 64'(busy), 64'd1);
    tick();
    @(negedge clk);
    check("gap_idle2", 64'(fifo.wr_en), 64'd0);
    tick();
    @(negedge clk);
    check("gap_wr2", 64'(fifo.wr_en), 64'd1);
    tick();
    @(negedge clk);
    check("gap_done",     64'(done),     64'd1);
    check("gap_count",    64'(wr_count), 64'd2);
    check("gap_sb_empty", 64'(exp_q.size()), 64'd0);
    tick();
    tick();

    // Zero-length burst
    start_burst(16'h0055, 16'd0, 8'd0);
    @(negedge clk);
    check("zero_done",  64'(done),       64'd1);
    check("zero_wr_en", 64'(fifo.wr_en), 64'd0);
    check("zero_count", 64'(wr_count),   64'd0);
    tick();
    @(negedge clk);
    check("zero_done_end", 64'(done), 64'd0);
    check("zero_idle",     64'(busy), 64'd0);
    tick();

    // Abort together with the second accepted write
    exp_q.push_back(16'h0200);
    exp_q.push_back(16'h0201);
    start_burst(16'h0200, 16'd8, 8'd0);
    @(negedge clk);
    check("abort_wr1", 64'(fifo.wr_en), 64'd1);
    tick();
    abort = 1'b1;
    @(negedge clk);
    check("abort_wr2", 64'(fifo.wr_en), 64'd1);
    tick();
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_idle",  64'(busy),          64'd0);
      check("abort_nodone", 64'(done),         64'd0);
      check("abort_wr_en", 64'(fifo.wr_en),    64'd0);
      check("abort_count", 64'(wr_count),      64'd2);
      check("abort_data",  64'(fifo.wr_data),  64'h0202);
      tick();
    end
    check("abort_sb_empty", 64'(exp_q.size()), 64'd0);
    // Abort while idle changes nothing
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_idle_noeff", 64'(wr_count), 64'd2);
    tick();

    // Reset during PAUSE, then a complete burst
    exp_q.push_back(16'h0300);
    start_burst(16'h0300, 16'd3, 8'd3);
    @(negedge clk);
    check("rstmid_wr1", 64'(fifo.wr_en), 64'd1);
    tick();
    @(negedge clk);
    check("rstmid_pause", 64'(busy), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rstmid_busy",  64'(busy),          64'd0);
    check("rstmid_done",  64'(done),          64'd0);
    check("rstmid_wr_en", 64'(fifo.wr_en),    64'd0);
    check("rstmid_count", 64'(wr_count),      64'd0);
    check("rstmid_data",  64'(fifo.wr_data),  64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rstmid_wait", 64'(busy), 64'd0);
      tick();
    end
    exp_q.push_back(16'h0400);
    exp_q.push_back(16'h0401);
    exp_q.push_back(16'h0402);
    start_burst(16'h0400, 16'd3, 8'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_wr_en", 64'(fifo.wr_en), (i % 2 == 0) ? 64'd1 : 64'd0);
      check("post_rst_nodn",  64'(done), 64'd0);
      tick();
    end
    @(negedge clk);
    check("post_rst_done",  64'(done),     64'd1);
    check("post_rst_count", 64'(wr_count), 64'd3);
    check("post_rst_sb",    64'(exp_q.size()), 64'd0);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_seq_writer.md
FIFO_SEQ_WRITER -- requirements
Module: fifo_seq_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the FIFO data width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, the burst-length and write-counter width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: begin a burst; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: terminate the current burst.
REQ-007 SHALL have port burst_len, input, CNT_W bits: number of words to write; captured at start.
REQ-008 SHALL have port gap_cycles, input, 8 bits: idle cycles after each accepted write; captured at start.
REQ-009 SHALL have port seed, input, WIDTH bits: value of the first data word; captured at start.
REQ-010 SHALL have port full, input, 1 bit: FIFO full flag from the write side.
REQ-011 SHALL have port wr_en, output, 1 bit: FIFO write enable.
REQ-012 SHALL have port wr_data, output, WIDTH bits: FIFO write data.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse marking burst completion.
REQ-015 SHALL have port wr_count, output, CNT_W bits: writes accepted in the current or last burst.

Function
REQ-016 SHALL implement the FSM states IDLE, WRITE, PAUSE and DONE.
REQ-017 SHALL go IDLE->WRITE on start=1, capture burst_len/gap_cycles/seed, clear wr_count, and load wr_data=seed.
REQ-018 SHALL go IDLE->DONE on start=1 with burst_len=0; no write issued.
REQ-019 SHALL drive wr_en = (state==WRITE) && !full, combinationally; wr_en SHALL never be high while full=1.
REQ-020 SHALL treat an accepted write as wr_en=1 at a rising clk edge; on that edge wr_count increments and wr_data advances to the next sequence value.
REQ-021 SHALL produce sequence value = previous + 1, modulo 2^WIDTH (wraps from all-ones to 0).
REQ-022 SHALL, after an accepted write that is not the last, go WRITE->PAUSE if captured gap_cycles>0 (else stay in WRITE); PAUSE lasts exactly gap_cycles cycles, then returns to WRITE.
REQ-023 SHALL go WRITE->DONE when wr_count reaches burst_len; DONE lasts one cycle with done=1, then IDLE.
REQ-024 SHALL, while full=1 in WRITE, hold state, wr_data and wr_count with no timeout.
REQ-025 SHALL, on abort=1 in WRITE or PAUSE, go to IDLE next cycle with no done pulse; a write accepted in that same cycle still counts.
REQ-026 SHALL ignore start while busy=1; abort in IDLE or DONE has no effect.
REQ-027 SHALL hold wr_data and wr_count stable in IDLE until the next start.

Reset
REQ-028 SHALL, on rst=1, asynchronously force state=IDLE, wr_en=0, busy=0, done=0, wr_count=0 and wr_data=0.
REQ-029 SHALL, when rst asserts mid-burst, abandon the burst without a done pulse; after rst deasserts the block waits for a new start.

Configuration
REQ-030 SHALL, when macro FIFO_SEQ_WRITER_LFSR_EN is defined, produce the next sequence value as one Galois LFSR step of the previous value (tap mask from the package); a seed of 0 SHALL be replaced by 1.
REQ-031 SHALL, without FIFO_SEQ_WRITER_LFSR_EN, use the incrementing sequence of REQ-021; all other behaviour SHALL be identical in both builds.

Structure
REQ-032 SHALL place the state enum type and the LFSR tap-mask constant in shared package fifo_seq_pkg.
REQ-033 SHALL implement the next-value function in sub-module fifo_seq_next, combinational, parameterised by WIDTH and selected by the macro.

Verification
REQ-034 SHALL verify a basic burst: seed=0x0010, burst_len=4, gap=0, full=0 -> wr_data 0x10, 0x11, 0x12, 0x13 on 4 consecutive cycles; done pulses on cycle 5; wr_count=4.
REQ-035 SHALL verify backpressure: burst_len=3, full high for 5 cycles after the first write -> wr_en low for exactly those 5 cycles, data order preserved, wr_count=3.
REQ-036 SHALL verify gaps and wrap: seed=0xFFFF, burst_len=2, gap=2 -> writes 0xFFFF and 0x0000 separated by 2 idle cycles.
REQ-037 SHALL verify a zero-length burst: burst_len=0 -> no wr_en, done one cycle after start, wr_count=0.
REQ-038 SHALL verify abort: abort asserted together with the 2nd accepted write of a burst_len=8 burst -> IDLE next cycle, wr_count=2, no done pulse.
REQ-039 SHALL verify reset mid-burst: rst pulsed during PAUSE -> all outputs 0 immediately; a subsequent start runs a full burst correctly.
